// File: rtl/cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_pkg : shared types and sizes for the command FIFO write path      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUSH    = 2'd2
  } cmd_state_t;

  localparam int CMD_WIDTH     = 32;
  localparam int BYTES_PER_CMD = 4;

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flex_counter : clearable up-counter, wraps to 0 after rollover_val    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      if (r_count == rollover_val) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/cmd_fifo_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_fifo_writer : packs 4 host bytes (LE) into a 32-bit FIFO command  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cmd_fifo_writer
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   write_clk,
  input  logic                   n_rst,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  input  logic                   flush,
  input  logic                   fifo_full,
  output logic                   write_command,
  output logic [CMD_WIDTH-1:0]   write_data,
  output logic                   busy,
  output logic                   frame_error,
  output logic [COUNT_WIDTH-1:0] cmd_count
);

  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] c_ST_IDLE    = IDLE;
  localparam logic [1:0] c_ST_COLLECT = COLLECT;
  localparam logic [1:0] c_ST_PUSH    = PUSH;

  localparam logic [1:0]             c_LAST_IDX = 2'(BYTES_PER_CMD - 1);
  localparam logic [c_TO_W-1:0]      c_TO_ROLL  = c_TO_W'(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0]      c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] c_CNT_MAX  = '1;

  logic [1:0]           r_state;
  logic [1:0]           r_index;
  logic [CMD_WIDTH-1:0] r_data;
  logic                 r_frame_error;

  logic              w_in_collect;
  logic              w_accept;
  logic              w_timeout;
  logic              w_leave_collect;
  logic              w_to_clear;
  logic [c_TO_W-1:0] w_to_count;

  assign w_in_collect  = (r_state == c_ST_COLLECT);
  assign byte_ready    = ((r_state == c_ST_IDLE) || w_in_collect) && !flush;
  assign w_accept      = byte_valid && byte_ready;
  assign write_command = (r_state == c_ST_PUSH) && !fifo_full;

  // The edge on which the idle count would reach TIMEOUT_CYCLES is the timeout edge.
  assign w_timeout       = w_in_collect && !flush && !w_accept && (w_to_count == c_TO_LAST);
  assign w_leave_collect = w_in_collect &&
                           (flush || w_timeout || (w_accept && (r_index == c_LAST_IDX)));
  assign w_to_clear      = w_accept || w_leave_collect;

  flex_counter #(
    .NUM_CNT_BITS (c_TO_W)
  ) u_timeout_cnt (
    .clk          (write_clk),
    .n_rst        (n_rst),
    .clear        (w_to_clear),
    .count_enable (w_in_collect),
    .rollover_val (c_TO_ROLL),
    .count_out    (w_to_count)
  );

  flex_counter #(
    .NUM_CNT_BITS (COUNT_WIDTH)
  ) u_cmd_cnt (
    .clk          (write_clk),
    .n_rst        (n_rst),
    .clear        (1'b0),
    .count_enable (write_command),
    .rollover_val (c_CNT_MAX),
    .count_out    (cmd_count)
  );

  always_ff @(posedge write_clk) begin
    if (!n_rst) begin
      r_state       <= c_ST_IDLE;
      r_index       <= 2'd0;
      r_data        <= '0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            r_state <= c_ST_COLLECT;
            r_index <= 2'd1;
            r_data  <= {{(CMD_WIDTH-8){1'b0}}, byte_data};
          end
        end
        c_ST_COLLECT: begin
          if (flush) begin
            r_state <= c_ST_IDLE;
            r_index <= 2'd0;
            r_data  <= '0;
          end else if (w_accept) begin
            r_data[{r_index, 3'b000} +: 8] <= byte_data;
            if (r_index == c_LAST_IDX) begin
              r_state <= c_ST_PUSH;
              r_index <= 2'd0;
            end else begin
              r_index <= r_index + 2'd1;
            end
          end else if (w_timeout) begin
            r_state       <= c_ST_IDLE;
            r_index       <= 2'd0;
            r_data        <= '0;
            r_frame_error <= 1'b1;
          end
        end
        // A complete word is never dropped: flush has no effect here.
        c_ST_PUSH: begin
          if (write_command) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_index <= 2'd0;
        end
      endcase
    end
  end

  assign write_data  = r_data;
  assign busy        = (r_state != c_ST_IDLE);
  assign frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_cmd_fifo_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cmd_fifo_writer : randomized scoreboard bench for cmd_fifo_writer  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cmd_fifo_writer;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          write_clk = 1'b0;
  logic          n_rst;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          flush;
  logic          fifo_full;
  logic          write_command;
  logic [31:0]   write_data;
  logic          busy;
  logic          frame_error;
  logic [CW-1:0] cmd_count;

  cmd_fifo_writer #(
    .TIMEOUT_CYCLES (TO),
    .COUNT_WIDTH    (CW)
  ) dut (
    .write_clk     (write_clk),
    .n_rst         (n_rst),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .flush         (flush),
    .fifo_full     (fifo_full),
    .write_command (write_command),
    .write_data    (write_data),
    .busy          (busy),
    .frame_error   (frame_error),
    .cmd_count     (cmd_count)
  );

  always #5 write_clk = ~write_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: bytes of the partial word, a pending complete word,
  // idle-cycle count and the number of words pushed.
  logic [31:0] exp_q[$];
  logic [7:0]  part_q[$];
  bit          pend;
  int          idle;
  bit          fe_flag;
  int          cnt;
  logic [31:0] hold_word;
  bit          hold_valid;

  bit          chk_en = 1'b0;
  bit          exp_ready, exp_wc, exp_busy, exp_fe, exp_hv;
  logic [CW-1:0] exp_cnt;
  logic [31:0] exp_hw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge write_clk) begin
    if (chk_en) begin
      check("byte_ready",    {31'b0, byte_ready},    {31'b0, exp_ready});
      check("write_command", {31'b0, write_command}, {31'b0, exp_wc});
      check("busy",          {31'b0, busy},          {31'b0, exp_busy});
      check("frame_error",   {31'b0, frame_error},   {31'b0, exp_fe});
      check("cmd_count",     32'(cmd_count),         32'(exp_cnt));
      if (exp_hv) check("write_data_hold", write_data, exp_hw);
      if (write_command === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_push: got data %h expected no push at %0t", write_data, $time);
        end else begin
          check("push_data", write_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    pend       = 1'b0;
    idle       = 0;
    fe_flag    = 1'b0;
    cnt        = 0;
    hold_word  = 32'h0;
    hold_valid = 1'b1;
  endtask

  // Applies one cycle of inputs; called at posedge+2, returns at the next posedge+2.
  task automatic step(input bit v, input logic [7:0] d, input bit fl, input bit full);
    bit          acc;
    logic [31:0] word;
    byte_valid = v;
    byte_data  = d;
    flush      = fl;
    fifo_full  = full;
    exp_ready  = !pend && !fl;
    acc        = v && exp_ready;
    exp_wc     = pend && !full;
    exp_busy   = pend || (part_q.size() > 0);
    exp_fe     = fe_flag;
    exp_cnt    = CW'(cnt);
    exp_hv     = hold_valid;
    exp_hw     = hold_word;
    chk_en     = 1'b1;
    @(posedge write_clk);
    fe_flag = 1'b0;
    if (pend) begin
      if (!full) begin
        pend = 1'b0;
        cnt++;
      end
    end else if (fl) begin
      if (part_q.size() > 0) begin
        part_q.delete();
        hold_word  = 32'h0;
        hold_valid = 1'b1;
      end
    end else if (acc) begin
      part_q.push_back(d);
      idle       = 0;
      hold_valid = 1'b0;
      if (part_q.size() == 4) begin
        word = {part_q[3], part_q[2], part_q[1], part_q[0]};
        exp_q.push_back(word);
        hold_word  = word;
        hold_valid = 1'b1;
        pend       = 1'b1;
        part_q.delete();
      end
    end else if (part_q.size() > 0) begin
      idle++;
      if (idle == TO) begin
        part_q.delete();
        hold_word  = 32'h0;
        hold_valid = 1'b1;
        fe_flag    = 1'b1;
      end
    end
    #2;
  endtask

  task automatic do_reset();
    chk_en     = 1'b0;
    n_rst      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    flush      = 1'b0;
    fifo_full  = 1'b0;
    @(posedge write_clk);
    @(posedge write_clk);
    model_reset();
    #2;
    n_rst = 1'b1;
  endtask

  initial begin
    do_reset();
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // Basic pack
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);

    // Back-pressure with flush and valid bytes offered while stalled
    step(1, 8'hEF, 0, 1);
    step(1, 8'hBE, 0, 1);
    step(1, 8'hAD, 0, 1);
    step(1, 8'hDE, 0, 1);
    for (int i = 0; i < 20; i++) step(i[0], 8'($urandom), i[1], 1);
    step(1, 8'h77, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);

    // Flush together with a valid byte
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 1, 0);
    step(1, 8'hA0, 0, 0);
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    step(1, 8'hA3, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 8'h00, 0, 0);

    // Timeout after one byte, then one byte just short of timing out
    step(1, 8'h55, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 8'h00, 0, 0);
    step(1, 8'h66, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 0, 0);
    step(1, 8'h67, 0, 0);
    step(1, 8'h68, 0, 0);
    step(1, 8'h69, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int j = 0; j < 10; j++) step(0, 8'h00, 0, $urandom_range(0, 3) == 0);
      end else begin
        step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 29) == 0,
             $urandom_range(0, 3) == 0);
      end
    end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);

    // Counter wrap: 17 words into a 4-bit count
    do_reset();
    for (int w = 0; w < 17; w++) begin
      for (int b = 0; b < 4; b++) step(1, 8'($urandom), 0, 0);
      step(0, 8'h00, 0, 0);
    end
    check("wrap_count", 32'(cmd_count), 32'd1);

    // Reset mid-word
    step(1, 8'hC0, 0, 0);
    step(1, 8'hC1, 0, 0);
    do_reset();
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    step(1, 8'hD0, 0, 0);
    step(1, 8'hD1, 0, 0);
    step(1, 8'hD2, 0, 0);
    step(1, 8'hD3, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
